// File: rtl/append_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// append_arbiter_ctrl
//   Round-robin sequencer that lets two requesters share one append register.
//   Requester 0 contributes symbol 2'b10 and requester 1 contributes 2'b11.
//   Symbols are shifted in from the top of a WIDTH-bit accumulator. A full
//   word, or a flushed partial word, is presented on a valid/ready port.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req0       in   requester 0 has a 2'b10 symbol (level)
//   req1       in   requester 1 has a 2'b11 symbol (level)
//   gnt0       out  combinational: req0 symbol is appended at this edge
//   gnt1       out  combinational: req1 symbol is appended at this edge
//   flush      in   emit the partial word (including any same-cycle grant)
//   out_valid  out  registered: out_data/out_cnt hold a word
//   out_ready  in   consumer accepts the word
//   out_data   out  packed word
//   out_cnt    out  number of symbols in out_data (1..NSYM)
//   sym_cnt    out  number of symbols currently accumulated
// ---------------------------------------------------------------------------
module append_arbiter_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH / 2 + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_cnt,
    output logic [CW-1:0]    sym_cnt
);

    localparam logic [CW-1:0] NSYM_C = CW'(WIDTH / 2);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    r_sym_cnt;
    logic [CW-1:0]    w_sym_cnt_nxt;
    logic             r_rr_last;
    logic             w_rr_last_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] w_out_data_nxt;
    logic [CW-1:0]    r_out_cnt;
    logic [CW-1:0]    w_out_cnt_nxt;

    logic             w_fill;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_any_gnt;
    logic [1:0]       w_sym;
    logic [WIDTH-1:0] w_acc_post;
    logic [CW-1:0]    w_cnt_post;
    logic             w_to_full;

    // Grant arbitration and the post-append view of the accumulator
    always_comb begin
        w_fill    = (r_state == S_FILL);
        // rr_last names the most recent winner; on a tie the other one wins.
        // Grants are gated by rst_n so they read 0 during reset.
        w_gnt0    = rst_n & w_fill & req0 & (~req1 | r_rr_last);
        w_gnt1    = rst_n & w_fill & req1 & (~req0 | ~r_rr_last);
        w_any_gnt = w_gnt0 | w_gnt1;
        w_sym     = w_gnt1 ? 2'b11 : 2'b10;
        if (w_any_gnt) begin
            w_acc_post = {w_sym, r_acc[WIDTH-1:2]};
        end else begin
            w_acc_post = r_acc;
        end
        w_cnt_post = r_sym_cnt + {{(CW-1){1'b0}}, w_any_gnt};
        // A flush at an empty count with no grant must not emit a word.
        w_to_full  = (w_any_gnt && (w_cnt_post == NSYM_C)) ||
                     (flush && (w_cnt_post != {CW{1'b0}}));
    end

    // Next-state and next-register logic for the FILL/FULL sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_sym_cnt_nxt   = r_sym_cnt;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_cnt_nxt   = r_out_cnt;
        w_rr_last_nxt   = r_rr_last;

        if (w_gnt0) begin
            w_rr_last_nxt = 1'b0;
        end else if (w_gnt1) begin
            w_rr_last_nxt = 1'b1;
        end else begin
            w_rr_last_nxt = r_rr_last;
        end

        case (r_state)
            S_FILL: begin
                w_acc_nxt     = w_acc_post;
                w_sym_cnt_nxt = w_cnt_post;
                if (w_to_full) begin
                    w_state_nxt     = S_FULL;
                    w_out_data_nxt  = w_acc_post;
                    w_out_cnt_nxt   = w_cnt_post;
                    w_out_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt     = S_FILL;
                end
            end
            S_FULL: begin
                // Word is held until accepted; out_data/out_cnt keep their
                // value after the handshake, only valid drops.
                if (out_ready) begin
                    w_state_nxt     = S_FILL;
                    w_out_valid_nxt = 1'b0;
                    w_acc_nxt       = {WIDTH{1'b0}};
                    w_sym_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt     = S_FULL;
                end
            end
            default: begin
                w_state_nxt     = S_FILL;
                w_acc_nxt       = {WIDTH{1'b0}};
                w_sym_cnt_nxt   = {CW{1'b0}};
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_acc       <= {WIDTH{1'b0}};
            r_sym_cnt   <= {CW{1'b0}};
            r_rr_last   <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_cnt   <= {CW{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_sym_cnt   <= w_sym_cnt_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_cnt   <= w_out_cnt_nxt;
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_cnt   = r_out_cnt;
    assign sym_cnt   = r_sym_cnt;

endmodule

// File: tb/tb_append_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_append_arbiter_ctrl
//   Directed bench for append_arbiter_ctrl with WIDTH=8. Inputs change just
//   after the falling edge; outputs are checked 1 time unit later, well away
//   from the rising edge where state updates.
// ---------------------------------------------------------------------------
module tb_append_arbiter_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH / 2 + 1);

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic             req1;
    logic             gnt0;
    logic             gnt1;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_cnt;
    logic [CW-1:0]    sym_cnt;

    int n_tests;
    int n_fail;

    append_arbiter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .sym_cnt   (sym_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, settle before checks.
    task automatic cyc(input logic r0, input logic r1, input logic fl, input logic rdy);
        @(negedge clk);
        req0      = r0;
        req1      = r1;
        flush     = fl;
        out_ready = rdy;
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic e0, input logic e1);
        chk({tag, "_gnt0"}, 32'(gnt0), 32'(e0));
        chk({tag, "_gnt1"}, 32'(gnt1), 32'(e1));
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req0      = 1'b1;
        req1      = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;

        // ---- 1: reset with both requests asserted
        @(negedge clk);
        #1;
        chk_gnt("rst", 1'b0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  32'(out_data),  32'h00);
        chk("rst_symcnt", 32'(sym_cnt),  32'd0);
        chk("rst_outcnt", 32'(out_cnt),  32'd0);

        // ---- 3: both requests from reset, alternating grants 0,1,0,1
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_gnt("rr_g1", 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_gnt("rr_g2", 1'b0, 1'b1);
        chk("rr_symcnt1", 32'(sym_cnt), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_gnt("rr_g3", 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk_gnt("rr_g4", 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rr_valid", 32'(out_valid), 32'd1);
        chk("rr_data",  32'(out_data),  32'hEE);
        chk("rr_cnt",   32'(out_cnt),   32'd4);
        chk_gnt("rr_full", 1'b0, 1'b0);

        // ---- 4: backpressure for 5 cycles, then handshake
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data),  32'hEE);
            chk("bp_cnt",   32'(out_cnt),   32'd4);
            chk_gnt("bp", 1'b0, 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("hs_valid", 32'(out_valid), 32'd1);
        chk_gnt("hs", 1'b0, 1'b0);

        // ---- 2: req0 only; first grant directly after the handshake
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_data",  32'(out_data),  32'hEE);
        chk("post_hs_symcnt", 32'(sym_cnt),  32'd0);
        chk_gnt("r0_g1", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            chk_gnt("r0_gn", 1'b1, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("r0_valid", 32'(out_valid), 32'd1);
        chk("r0_data",  32'(out_data),  32'hAA);
        chk("r0_cnt",   32'(out_cnt),   32'd4);
        chk_gnt("r0_bubble", 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("r0_valid_drop", 32'(out_valid), 32'd0);
        chk_gnt("r0_resume", 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk_gnt("r0_resume2", 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_symcnt", 32'(sym_cnt), 32'd2);

        // ---- 6: async reset mid-word
        #2;
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        #1;
        chk("ar_symcnt", 32'(sym_cnt),   32'd0);
        chk("ar_valid",  32'(out_valid), 32'd0);
        chk("ar_data",   32'(out_data),  32'h00);
        chk_gnt("ar", 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("ar_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_gnt("ar_rel", 1'b1, 1'b0);

        // Clean restart for the flush cases
        #2;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---- 5a: single req1 symbol then flush alone
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk_gnt("f1_g", 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk_gnt("f1_fl", 1'b0, 1'b0);
        chk("f1_pre_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f1_valid", 32'(out_valid), 32'd1);
        chk("f1_data",  32'(out_data),  32'hC0);
        chk("f1_cnt",   32'(out_cnt),   32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f1_done", 32'(out_valid), 32'd0);

        // ---- 5b: req1 symbol, then req0 granted with flush in same cycle
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk_gnt("f2_g1", 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk_gnt("f2_g2", 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f2_valid", 32'(out_valid), 32'd1);
        chk("f2_data",  32'(out_data),  32'hB0);
        chk("f2_cnt",   32'(out_cnt),   32'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("f2_done", 32'(out_valid), 32'd0);

        // ---- 5c: flush with nothing accumulated is ignored
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("f3_symcnt", 32'(sym_cnt), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("f3_valid1", 32'(out_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("f3_valid2", 32'(out_valid), 32'd0);
        chk("f3_data_kept", 32'(out_data), 32'hB0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
